// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding,
// duty-code width, divider length, glitch-filter length and the duty
// saturation helper.
package pwm_capture_pkg;

  typedef enum logic [0:0] {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } cap_state_t;

  localparam int unsigned DUTY_W   = 4;
  localparam int unsigned DIV_CYC  = 5;
  localparam int unsigned FILT_LEN = 3;

  // Quotients of 16 or more (only possible when high == period) map to 15.
  function automatic logic [DUTY_W-1:0] sat_duty(input logic [DIV_CYC-1:0] q);
    return q[DIV_CYC-1] ? '1 : q[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_cap_div.sv
// Restoring unsigned divider producing a 5-bit quotient of num/den, one
// quotient bit per cycle. The caller guarantees num < 32*den, so only the
// five low numerator bits need to be shifted through the remainder.
// start/busy/done handshake: done is high for exactly one cycle, and busy
// stays high for one more cycle after done.
module pwm_cap_div
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W = 24
) (
  input  logic               clk_i,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W+3:0]   num,
  input  logic [CNT_W-1:0]   den,
  output logic               busy,
  output logic               done,
  output logic [DIV_CYC-1:0] q
);

  logic [CNT_W-1:0]   rem;
  logic [CNT_W-1:0]   den_q;
  logic [DIV_CYC-1:0] lo;
  logic [2:0]         step;
  logic               load;
  logic [CNT_W-1:0]   rem_src;
  logic [CNT_W-1:0]   den_src;
  logic               bit_src;
  logic [CNT_W:0]     trial;
  logic               ge;
  logic [CNT_W-1:0]   rem_nxt;

  assign load = start && !busy;
  assign done = busy && (step == 3'(DIV_CYC));

  // One restoring step. In the load cycle it works directly on num/den, so
  // the first quotient bit is produced while the operands are captured.
  always_comb begin
    rem_src = load ? {1'b0, num[CNT_W+3:DIV_CYC]} : rem;
    bit_src = load ? num[DIV_CYC-1] : lo[DIV_CYC-1];
    den_src = load ? den : den_q;
    trial   = {rem_src, bit_src};
    ge      = (trial >= {1'b0, den_src});
    rem_nxt = ge ? (trial[CNT_W-1:0] - den_src) : trial[CNT_W-1:0];
  end

  // Iteration control: bits 4..0 over five edges, then one result cycle,
  // then one extra busy cycle before accepting a new start.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      busy  <= 1'b0;
      step  <= '0;
      rem   <= '0;
      den_q <= '0;
      lo    <= '0;
      q     <= '0;
    end else if (load) begin
      busy  <= 1'b1;
      step  <= 3'd1;
      rem   <= rem_nxt;
      den_q <= den;
      lo    <= {num[DIV_CYC-2:0], 1'b0};
      q     <= {{(DIV_CYC-1){1'b0}}, ge};
    end else if (busy) begin
      if (step < 3'(DIV_CYC)) begin
        rem  <= rem_nxt;
        lo   <= {lo[DIV_CYC-2:0], 1'b0};
        q    <= {q[DIV_CYC-2:0], ge};
        step <= step + 3'd1;
      end else if (step == 3'(DIV_CYC)) begin
        step <= step + 3'd1;
      end else begin
        busy <= 1'b0;
        step <= '0;
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period (clk_i cycles between rising edges) and duty
// as a 4-bit sixteenths code. Holds the input synchronizer, the optional
// glitch filter, the period/high counters, the FSM and the output registers.
// Optional feature: define PWM_CAP_GLITCH_FILTER_EN to insert a filter that
// accepts a level change only after 3 equal consecutive synced samples.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned TIMEOUT = 2_000_000
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              pwm_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic [CNT_W-1:0]  period_o,
  output logic              valid_o,
  output logic              timeout_o,
  output logic              overrun_o
);

  logic sync_a;
  logic sync_b;
  logic lvl_in;
  logic lvl;
  logic rise_q;

  cap_state_t         state;
  logic [CNT_W-1:0]   period_cnt;
  logic [CNT_W-1:0]   high_cnt;
  logic [CNT_W-1:0]   p_q;
  logic [CNT_W-1:0]   p_next;
  logic               div_start;
  logic               div_busy;
  logic               div_done;
  logic [DIV_CYC-1:0] div_q;
  logic               tmo_hit;

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= pwm_i;
      sync_b <= sync_a;
    end
  end

`ifdef PWM_CAP_GLITCH_FILTER_EN
  logic [FILT_LEN-2:0] hist;
  logic                filt_q;

  // Sample history and last accepted level of the glitch filter.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      hist   <= '0;
      filt_q <= 1'b0;
    end else begin
      hist   <= {hist[FILT_LEN-3:0], sync_b};
      filt_q <= lvl_in;
    end
  end

  // New level accepted in the same cycle the third equal sample arrives.
  always_comb begin
    lvl_in = (hist == {(FILT_LEN-1){sync_b}}) ? sync_b : filt_q;
  end
`else
  assign lvl_in = sync_b;
`endif

  // Registered rise flag; lvl is the level aligned with rise_q.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      lvl    <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      lvl    <= lvl_in;
      rise_q <= lvl_in & ~lvl;
    end
  end

  assign p_next    = period_cnt + CNT_W'(1);
  assign div_start = (state == ST_RUN) && rise_q && !div_busy;
  assign tmo_hit   = !rise_q && (period_cnt == CNT_W'(TIMEOUT - 1));

  pwm_cap_div #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk_i (clk_i),
    .reset (reset),
    .start (div_start),
    .num   ({high_cnt, 4'b0000}),
    .den   (p_next),
    .busy  (div_busy),
    .done  (div_done),
    .q     (div_q)
  );

  // FSM, counters and output registers. In ST_SYNC period_cnt acts only
  // as the stuck-input timer; high_cnt stays at 0 there. The rise cycle
  // belongs to the new period, so high_cnt restarts at 1 (lvl is 1 then).
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state      <= ST_SYNC;
      period_cnt <= '0;
      high_cnt   <= '0;
      p_q        <= '0;
      duty_o     <= '0;
      period_o   <= '0;
      valid_o    <= 1'b0;
      timeout_o  <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (div_done) begin
        valid_o   <= 1'b1;
        duty_o    <= sat_duty(div_q);
        period_o  <= p_q;
        timeout_o <= 1'b0;
      end
      if (rise_q) begin
        period_cnt <= '0;
        high_cnt   <= CNT_W'(1);
        if (state == ST_SYNC) begin
          state <= ST_RUN;
        end else if (div_busy) begin
          overrun_o <= 1'b1;
        end else begin
          p_q <= p_next;
        end
      end else if (tmo_hit) begin
        valid_o    <= 1'b1;
        period_o   <= '0;
        duty_o     <= lvl ? '1 : '0;
        timeout_o  <= 1'b1;
        state      <= ST_SYNC;
        period_cnt <= '0;
        high_cnt   <= '0;
      end else begin
        period_cnt <= period_cnt + CNT_W'(1);
        if (state == ST_RUN) begin
          high_cnt <= high_cnt + CNT_W'(lvl);
        end else begin
          high_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture. Each phase builds an input waveform,
// a reference model derives the expected strobes from rising-edge times and
// high-sample counts, and a monitor compares every valid_o strobe.
module tb_pwm_capture;

  localparam int unsigned CNT_W = 24;
  localparam int          TMO   = 100;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pwm = 1'b0;
  logic [3:0]       duty;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             timeout;
  logic             overrun;

  pwm_capture #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TMO)
  ) dut (
    .clk_i     (clk),
    .reset     (reset),
    .pwm_i     (pwm),
    .duty_o    (duty),
    .period_o  (period),
    .valid_o   (valid),
    .timeout_o (timeout),
    .overrun_o (overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cycle;
    logic [3:0]  duty;
    int unsigned period;
    logic        tmo;
  } exp_t;

  exp_t q[$];
  bit   wave[$];
  bit   u[];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit wa(input int i);
    return (i < 0) ? 1'b0 : wave[i];
  endfunction

  function automatic bit ua(input int i);
    return (i < 0) ? 1'b0 : u[i];
  endfunction

  task automatic add_seg(input int p, input int h);
    for (int i = 0; i < p; i++) wave.push_back(i < h);
  endtask

  task automatic add_level(input bit v, input int len);
    for (int i = 0; i < len; i++) wave.push_back(v);
  endtask

  task automatic add_glitch_seg(input int p, input int h, input int g);
    int base_i;
    base_i = wave.size();
    add_seg(p, h);
    wave[base_i + g] = 1'b0;
  endtask

  // Reference model: derive strobes from rise times and high counts.
  task automatic build_model(input int unsigned base, output bit ovr);
    int   n;
    int   er[$];
    int   a, last, div_free, idx, e, tc, h, p, d;
    bit   run;
    exp_t x;
    n = wave.size();
    u = new[n];
    for (int i = 0; i < n; i++) begin
`ifdef PWM_CAP_GLITCH_FILTER_EN
      if (wa(i) == wa(i - 1) && wa(i - 1) == wa(i - 2)) u[i] = wave[i];
      else u[i] = ua(i - 1);
`else
      u[i] = wave[i];
`endif
    end
    for (int i = 0; i < n; i++)
      if (u[i] && !ua(i - 1)) er.push_back(i + 3);
    a = -1; last = 0; div_free = 0; run = 0; ovr = 0; idx = 0;
    forever begin
      e = (idx < er.size()) ? er[idx] : 32'h7fff_ffff;
      if (e <= a + TMO) begin
        if (e >= n) break;
        idx++;
        if (!run) begin
          run = 1;
        end else if (e >= div_free) begin
          p = e - last;
          h = 0;
          for (int c = last; c < e; c++) h += int'(ua(c - 3));
          d = (h * 16) / p;
          if (d > 15) d = 15;
          if (e + 6 <= n) begin
            x.cycle = base + e + 6; x.duty = 4'(d); x.period = p; x.tmo = 0;
            q.push_back(x);
          end
          div_free = e + 7;
        end else begin
          ovr = 1;
        end
        last = e;
        a = e;
      end else begin
        tc = a + TMO;
        if (tc + 1 > n) break;
        x.cycle = base + tc + 1; x.duty = ua(tc - 3) ? 4'd15 : 4'd0;
        x.period = 0; x.tmo = 1;
        q.push_back(x);
        a = tc;
        run = 0;
      end
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe at cycle %0d duty %0d period %0d required none",
                 cyc, duty, period);
      end else begin
        e = q.pop_front();
        check("strobe_cycle", cyc, e.cycle);
        check("duty", duty, e.duty);
        check("period", period, e.period);
        check("timeout_flag", timeout, e.tmo);
      end
    end
  end

  // Drive the built waveform from reset release, then reset again.
  task automatic run_phase();
    int unsigned base;
    bit          ovr;
    int          n;
    n = wave.size();
    @(negedge clk);
    base = cyc;
    check("reset_duty", duty, 0);
    check("reset_period", period, 0);
    check("reset_valid", valid, 0);
    check("reset_timeout", timeout, 0);
    check("reset_overrun", overrun, 0);
    build_model(base, ovr);
    reset = 1'b0;
    pwm   = wave[0];
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      pwm = wave[i];
    end
    @(negedge clk);
    check("overrun", overrun, ovr);
    reset = 1'b1;
    pwm   = 1'b0;
    @(posedge clk);
    #1;
    check("pending_strobes", q.size(), 0);
    q.delete();
    wave.delete();
    @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);

    // period 16, high 4
    for (int i = 0; i < 8; i++) add_seg(16, 4);
    add_level(0, 20);
    run_phase();

    // 40/20, 40/39, then stuck high
    for (int i = 0; i < 3; i++) add_seg(40, 20);
    for (int i = 0; i < 3; i++) add_seg(40, 39);
    add_level(1, 250);
    run_phase();

    // stuck low then recovery
    add_level(0, 120);
    for (int i = 0; i < 3; i++) add_seg(20, 10);
    add_level(0, 10);
    run_phase();

    // period 4 forces overruns
    for (int i = 0; i < 20; i++) add_seg(4, 2);
    add_level(0, 10);
    run_phase();

    // reset three cycles after the third rise is flagged
    add_seg(16, 8);
    add_seg(16, 8);
    add_level(1, 6);
    run_phase();

    // one-cycle low glitch inside the high phase
    for (int i = 0; i < 6; i++) add_glitch_seg(32, 16, 8);
    add_level(0, 10);
    run_phase();

    // random periods
    for (int i = 0; i < 40; i++) begin
      int p;
      p = int'($urandom_range(60, 3));
      add_seg(p, int'($urandom_range(p - 1, 1)));
    end
    add_level(0, 20);
    run_phase();

    // random short periods
    for (int i = 0; i < 40; i++) begin
      int p;
      p = int'($urandom_range(12, 2));
      add_seg(p, int'($urandom_range(p - 1, 1)));
    end
    add_level(0, 20);
    run_phase();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
